// File: rtl/fetch_pkg.sv
// fetch_pkg: types and constants shared by the fetch unit and its queue.
// Holds the queued fetch entry layout, the default reset PC and a helper
// that derives the queue pointer width from the queue depth.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One fetched instruction plus the prediction made for it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } fetch_entry_t;

  // Pointer width for a power-of-two queue depth (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t with flush.
// DEPTH must be a power of two >= 2. The pointers wrap naturally, and count
// carries one extra bit so that full is simply its MSB. A flush empties the
// queue and overrides push and pop in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign full_o    = r_count[PTR_W];
  assign empty_o   = (r_count == '0);
  // A push is refused while full, even if a pop frees a slot this cycle.
  assign w_push_ok = push_i && !full_o && !flush_i;
  assign w_pop_ok  = pop_i && !empty_o && !flush_i;
  assign data_o    = r_mem[r_rd_ptr];

  // Storage: write the accepted entry at the tail.
  // NOTE: the storage array has no reset; count and pointers alone decide which slots are live.
  always_ff @(posedge clk_i) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: PC register, next-PC selection and an instruction queue
// that decouples instruction fetch from decode.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a fetch straight
// to the decode outputs when the queue is empty (zero-cycle latency). If the
// macro is left undefined, decode is fed only from queue storage.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_req_o,
  input  logic        imem_valid_i,
  input  logic [31:0] instr_f_i,
  input  logic        predict_taken_i,
  input  logic [31:0] predict_pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        decode_ready_i,
  output logic        valid_d_o,
  output logic [31:0] instr_d_o,
  output logic [31:0] pc_d_o,
  output logic [31:0] pc_plus_4_d_o,
  output logic        predict_taken_d_o,
  output logic [31:0] predict_pc_d_o
);

  logic [31:0]  r_pc;
  logic [31:0]  w_pred_target;
  logic [31:0]  w_next_pc;
  logic         w_fire;
  logic         w_bypass;
  logic         w_push;
  logic         w_pop;
  logic         w_q_full;
  logic         w_q_empty;
  logic         w_out_valid;
  fetch_entry_t w_fetch_entry;
  logic [31:0]  w_fetch_instr;
  logic         w_fetch_taken;
  fetch_entry_t w_head_entry;
  fetch_entry_t w_out_entry;
  logic         w_unused;

  // Only the word-aligned parts of the target PCs are used.
  assign w_unused = ^{predict_pc_i[1:0], redirect_pc_i[1:0]};

  assign w_pred_target = {predict_pc_i[31:2], 2'b00};
  assign w_next_pc     = predict_taken_i ? w_pred_target : (r_pc + 32'd4);

  assign imem_addr_o = r_pc;
  assign imem_req_o  = !w_q_full && !redirect_i;
  assign w_fire      = imem_req_o && imem_valid_i;

  assign w_fetch_instr = instr_f_i;
  assign w_fetch_taken = predict_taken_i;
  assign w_fetch_entry = '{pc: r_pc, instr: w_fetch_instr,
                           pred_taken: w_fetch_taken, pred_pc: w_next_pc};

`ifdef FETCH_QUEUE_BYPASS_EN
  // w_fire already excludes redirect cycles, because a redirect drops the request.
  assign w_bypass = w_q_empty && w_fire;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed entry that decode takes immediately never occupies a slot.
  assign w_push = w_fire && !(w_bypass && decode_ready_i);
  assign w_pop  = !w_q_empty && decode_ready_i;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_fetch_entry),
    .data_o  (w_head_entry),
    .full_o  (w_q_full),
    .empty_o (w_q_empty)
  );

  // PC register: reset, then redirect, then advance on each fired fetch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc <= RESET_PC;
    end else if (redirect_i) begin
      r_pc <= {redirect_pc_i[31:2], 2'b00};
    end else if (w_fire) begin
      r_pc <= w_next_pc;
    end
  end

  // Decode-side source select: bypassed fetch, then queue head, else idle zeros.
  always_comb begin
    // NOTE: every variable gets a default first, so no path through the block can infer a latch.
    w_out_valid = 1'b0;
    w_out_entry = '0;
    if (w_bypass) begin
      w_out_valid = 1'b1;
      w_out_entry = w_fetch_entry;
    end else if (!w_q_empty) begin
      w_out_valid = 1'b1;
      w_out_entry = w_head_entry;
    end
  end

  assign valid_d_o         = w_out_valid;
  assign instr_d_o         = w_out_entry.instr;
  assign pc_d_o            = w_out_entry.pc;
  assign pc_plus_4_d_o     = w_out_valid ? (w_out_entry.pc + 32'd4) : 32'd0;
  assign predict_taken_d_o = w_out_entry.pred_taken;
  assign predict_pc_d_o    = w_out_entry.pred_pc;

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: scoreboard bench for fetch_prefetch (QUEUE_DEPTH = 4,
// RESET_PC = 0). Each fetch issued by the stimulus pushes its hand-computed
// entry into a queue. A monitor pops that queue and compares it on every
// decode handshake. The instruction memory returns ~address.
module tb_fetch_prefetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk;
  logic        rst_i;
  logic [31:0] imem_addr_o;
  logic        imem_req_o;
  logic        imem_valid_i;
  logic [31:0] instr_f_i;
  logic        predict_taken_i;
  logic [31:0] predict_pc_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        decode_ready_i;
  logic        valid_d_o;
  logic [31:0] instr_d_o;
  logic [31:0] pc_d_o;
  logic [31:0] pc_plus_4_d_o;
  logic        predict_taken_d_o;
  logic [31:0] predict_pc_d_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] pred_pc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_prefetch #(
    .QUEUE_DEPTH (4),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .imem_addr_o       (imem_addr_o),
    .imem_req_o        (imem_req_o),
    .imem_valid_i      (imem_valid_i),
    .instr_f_i         (instr_f_i),
    .predict_taken_i   (predict_taken_i),
    .predict_pc_i      (predict_pc_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i),
    .decode_ready_i    (decode_ready_i),
    .valid_d_o         (valid_d_o),
    .instr_d_o         (instr_d_o),
    .pc_d_o            (pc_d_o),
    .pc_plus_4_d_o     (pc_plus_4_d_o),
    .predict_taken_d_o (predict_taken_d_o),
    .predict_pc_d_o    (predict_pc_d_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: same-cycle read returning the inverted address.
  assign instr_f_i = ~imem_addr_o;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every real dequeue and compare the entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && !redirect_i && valid_d_o === 1'b1 && decode_ready_i) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_dequeue: got pc 0x%08h, expected no entry", pc_d_o);
      end else begin
        e = sb_q.pop_front();
        check("d_pc", pc_d_o, e.pc);
        check("d_instr", instr_d_o, e.instr);
        check("d_pc_plus_4", pc_plus_4_d_o, e.pc + 32'd4);
        check("d_pred_taken", {31'd0, predict_taken_d_o}, {31'd0, e.taken});
        check("d_pred_pc", predict_pc_d_o, e.pred_pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle in which a fetch at pc is expected to fire; exp_v < 0 skips the valid check.
  task automatic fetch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic [31:0] exp_pred_pc, input int exp_v);
    exp_t e;
    imem_valid_i    = 1'b1;
    predict_taken_i = taken;
    predict_pc_i    = tgt;
    e.pc      = pc;
    e.instr   = ~pc;
    e.taken   = taken;
    e.pred_pc = exp_pred_pc;
    sb_q.push_back(e);
    @(negedge clk);
    check("fetch_addr", imem_addr_o, pc);
    check("fetch_req", {31'd0, imem_req_o}, 32'd1);
    if (exp_v >= 0) check("fetch_valid_d", {31'd0, valid_d_o}, exp_v);
    step();
    imem_valid_i    = 1'b0;
    predict_taken_i = 1'b0;
    predict_pc_i    = 32'd0;
  endtask

  // One cycle in which no fetch is expected to fire.
  task automatic stall_cycle(input logic v, input logic exp_req, input logic [31:0] exp_addr,
                             input int exp_v);
    imem_valid_i = v;
    @(negedge clk);
    check("stall_req", {31'd0, imem_req_o}, {31'd0, exp_req});
    check("stall_addr", imem_addr_o, exp_addr);
    if (exp_v >= 0) check("stall_valid_d", {31'd0, valid_d_o}, exp_v);
    step();
    imem_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i           = 1'b1;
    imem_valid_i    = 1'b0;
    predict_taken_i = 1'b0;
    predict_pc_i    = 32'd0;
    redirect_i      = 1'b0;
    redirect_pc_i   = 32'd0;
    decode_ready_i  = 1'b0;
    step();
    step();
    sb_q.delete();
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_valid_d", {31'd0, valid_d_o}, 32'd0);
    check("rst_req", {31'd0, imem_req_o}, 32'd1);
    check("rst_addr", imem_addr_o, RST_PC);
    step();
  endtask

  initial begin
    // Sequential stream with decode always ready: PCs 0..0x1C, one per cycle.
    do_reset();
    decode_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fetch(32'(i * 4), 1'b0, 32'd0, 32'(i * 4 + 4), (i == 0) ? BYP : 1);
    end
    stall_cycle(1'b0, 1'b1, 32'h20, -1);
    stall_cycle(1'b0, 1'b1, 32'h20, 0);
    check("stream_drained", sb_q.size(), 32'd0);

    // Decode stalled: four fetches fill the queue, then the request drops and the PC holds.
    do_reset();
    decode_ready_i = 1'b0;
    fetch(32'h0, 1'b0, 32'd0, 32'h4, BYP);
    fetch(32'h4, 1'b0, 32'd0, 32'h8, 1);
    fetch(32'h8, 1'b0, 32'd0, 32'hC, 1);
    fetch(32'hC, 1'b0, 32'd0, 32'h10, 1);
    stall_cycle(1'b1, 1'b0, 32'h10, 1);
    stall_cycle(1'b1, 1'b0, 32'h10, 1);
    // Full queue with a dequeue: no enqueue this cycle, fetch resumes next cycle.
    decode_ready_i = 1'b1;
    stall_cycle(1'b1, 1'b0, 32'h10, 1);
    fetch(32'h10, 1'b0, 32'd0, 32'h14, 1);
    fetch(32'h14, 1'b0, 32'd0, 32'h18, 1);
    stall_cycle(1'b0, 1'b1, 32'h18, 1);
    stall_cycle(1'b0, 1'b1, 32'h18, 1);
    stall_cycle(1'b0, 1'b1, 32'h18, 1);
    stall_cycle(1'b0, 1'b1, 32'h18, 0);
    check("full_drained", sb_q.size(), 32'd0);

    // Taken prediction at 0x8 toward 0x103: low bits are dropped, so the next fetch is 0x100.
    do_reset();
    decode_ready_i = 1'b1;
    fetch(32'h0, 1'b0, 32'd0, 32'h4, BYP);
    fetch(32'h4, 1'b0, 32'd0, 32'h8, 1);
    fetch(32'h8, 1'b1, 32'h103, 32'h100, 1);
    fetch(32'h100, 1'b0, 32'd0, 32'h104, 1);
    fetch(32'h104, 1'b0, 32'd0, 32'h108, 1);
    stall_cycle(1'b0, 1'b1, 32'h108, -1);
    stall_cycle(1'b0, 1'b1, 32'h108, 0);
    check("pred_drained", sb_q.size(), 32'd0);

    // Redirect to 0x203 with three entries queued: the queue is flushed and fetch restarts at 0x200.
    do_reset();
    decode_ready_i = 1'b0;
    fetch(32'h0, 1'b0, 32'd0, 32'h4, BYP);
    fetch(32'h4, 1'b0, 32'd0, 32'h8, 1);
    fetch(32'h8, 1'b0, 32'd0, 32'hC, 1);
    redirect_i     = 1'b1;
    redirect_pc_i  = 32'h203;
    imem_valid_i   = 1'b1;
    decode_ready_i = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("redir_req", {31'd0, imem_req_o}, 32'd0);
    step();
    redirect_i   = 1'b0;
    imem_valid_i = 1'b0;
    fetch(32'h200, 1'b0, 32'd0, 32'h204, BYP);
    fetch(32'h204, 1'b0, 32'd0, 32'h208, 1);
    stall_cycle(1'b0, 1'b1, 32'h208, -1);
    stall_cycle(1'b0, 1'b1, 32'h208, 0);
    check("redir_drained", sb_q.size(), 32'd0);

    // Single fetch into an empty queue with decode ready: bypass (if built) leaves nothing queued.
    do_reset();
    decode_ready_i = 1'b1;
    fetch(32'h0, 1'b0, 32'd0, 32'h4, BYP);
    stall_cycle(1'b0, 1'b1, 32'h4, 1 - BYP);
    stall_cycle(1'b0, 1'b1, 32'h4, 0);
    check("single_drained", sb_q.size(), 32'd0);

    // Reset in mid-operation discards the queued entries.
    decode_ready_i = 1'b0;
    fetch(32'h4, 1'b0, 32'd0, 32'h8, BYP);
    fetch(32'h8, 1'b0, 32'd0, 32'hC, 1);
    do_reset();
    decode_ready_i = 1'b1;
    fetch(32'h0, 1'b0, 32'd0, 32'h4, BYP);
    stall_cycle(1'b0, 1'b1, 32'h4, -1);
    stall_cycle(1'b0, 1'b1, 32'h4, 0);
    check("midrst_drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised fetch unit with a decoupling instruction queue between the PC/instruction-memory side and the decode stage. Each cycle it fetches one word at the current PC and steers the next PC by the branch predictor. It buffers fetched entries, including PC and prediction, in a QUEUE_DEPTH-entry FIFO. The FIFO absorbs decode stalls without stalling fetch. Redirects from decode/execute flush the queue and restart fetch at the corrected PC.

## Interface
- QUEUE_DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous active-high reset
- imem_addr_o  output  32  fetch address (= current PC, word aligned)
- imem_req_o  output  1  fetch request; high when the queue is not full and redirect_i is low
- imem_valid_i  input  1  instr_f_i valid this cycle (same-cycle read)
- instr_f_i  input  32  fetched instruction word
- predict_taken_i  input  1  predictor says taken for imem_addr_o
- predict_pc_i  input  32  predicted target for imem_addr_o
- redirect_i  input  1  misprediction/jump correction from later stage
- redirect_pc_i  input  32  corrected fetch PC
- decode_ready_i  input  1  decode accepts head entry (= !stall_d)
- valid_d_o  output  1  head entry valid
- instr_d_o  output  32  head instruction
- pc_d_o  output  32  head PC
- pc_plus_4_d_o  output  32  head PC + 4
- predict_taken_d_o  output  1  prediction recorded for head
- predict_pc_d_o  output  32  predicted next PC recorded for head

## Operation
- Fetch fires when imem_req_o && imem_valid_i.
  - Enqueues {pc, instr_f_i, predict_taken_i, next_pc}.
  - next_pc = predict_taken_i ? predict_pc_i : pc + 4, computed mod 2^32 with no overflow flag; the PC register loads next_pc.
- No fetch fires when imem_valid_i is low or the queue is full; the PC is held.
- Dequeue when valid_d_o && decode_ready_i; head advances.
- Full means count == QUEUE_DEPTH. Enqueue is blocked while full, even when a dequeue happens the same cycle (no full bypass).
- Simultaneous enqueue and dequeue when not full leaves count unchanged; both pointers advance.
- Pointers are log2(QUEUE_DEPTH) bits and wrap naturally. Count is log2(QUEUE_DEPTH)+1 bits.
- Redirect has priority over everything:
  - count ← 0 and both pointers ← 0;
  - PC ← {redirect_pc_i[31:2], 2'b00};
  - no enqueue or dequeue takes effect that cycle.
- predict_pc_i[1:0] are forced to 00 before use.
- Data outputs are don't-care when valid_d_o = 0; the bench must not check them.

## Timing
- Reset values:
  - PC = RESET_PC; count = 0; pointers = 0.
  - valid_d_o = 0, imem_req_o = 1 (the first cycle after reset is a fetch cycle).
  - All data outputs are 0.
- Reset mid-operation discards all queued entries, identically to a redirect to RESET_PC.
- Latency: an instruction fetched in cycle N is visible at the decode outputs in cycle N+1 (base build).
- After a redirect in cycle N, fetch at redirect_pc_i happens in cycle N+1, and valid_d_o is earliest in cycle N+2.
- Steady state: one fetch and one dequeue per cycle, giving 1 instr/cycle.
- With decode stalled, exactly QUEUE_DEPTH further fetches complete, then imem_req_o drops.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined: bypass applies when the queue is empty, fetch fires and redirect_i is low.
  - The decode outputs are driven combinationally from the fetch (instr_f_i, PC, prediction) with valid_d_o = 1.
  - If decode_ready_i is high, the entry is consumed and not enqueued; otherwise it is enqueued normally.
  - Fetch-to-decode latency becomes 0 cycles.
- Undefined: no bypass; decode outputs come from queue storage only; 1-cycle latency.

## Structure
- fetch_pkg holds:
  - fetch_entry_t packed struct {pc, instr, pred_taken, pred_pc};
  - the default RESET_PC constant;
  - a clog2-derived pointer-width localparam helper.
- Sub-module fetch_queue is a generic synchronous FIFO of fetch_entry_t with flush, push, pop, full and empty.
- fetch_prefetch itself contains the PC register, next-PC selection and bypass logic.

## Test plan
- Reset, then decode_ready_i = 1 and imem_valid_i = 1, no predictions, RESET_PC = 0 → decode sees PCs 0, 4, 8, ... on consecutive cycles starting the cycle after the first fetch.
- Hold decode_ready_i = 0 with QUEUE_DEPTH = 4 → imem_req_o drops after 4 fetches; PC held at 0x10; releasing drains PCs 0, 4, 8, C in order.
- Predictor returns taken to 0x100 at PC 0x8 → entry 0x8 has predict_pc_d_o = 0x100; the next fetched PC is 0x100.
- Queue holding 3 entries, then redirect_i with redirect_pc_i = 0x203 → valid_d_o = 0 next cycle; fetch at 0x200; first valid entry PC = 0x200.
- Full queue with simultaneous dequeue → count goes 4→3 and no enqueue that cycle; the next cycle fetch resumes.
- FETCH_QUEUE_BYPASS_EN defined, empty queue, decode ready → instr_f_i appears on instr_d_o in the same cycle and count stays 0.
